// File: rtl/bitwise_alu_pipe.sv
// Two-stage valid/ready bitwise ALU with an XOR accumulator and zero/parity flags.
// Optional popcount output enabled by defining BITWISE_POPCNT_EN.
module bitwise_alu_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
`ifdef BITWISE_POPCNT_EN
  output logic             out_par,
  output logic [$clog2(WIDTH+1)-1:0] out_pop
`else
  output logic             out_par
`endif
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOT  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_ACC  = 3'd7
  } op_e;

  logic             s1_v;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_in1;
  logic [WIDTH-1:0] s1_in2;
  logic [WIDTH-1:0] acc;

  logic             s2_adv_c;
  logic             s1_adv_c;
  logic             xfer_c;
  logic [WIDTH-1:0] acc_base_c;
  logic [WIDTH-1:0] res_c;

  // Handshake: a stage may load when it is empty or the stage after it moves.
  always_comb begin
    s2_adv_c = ~out_valid | out_ready;
    s1_adv_c = ~s1_v | s2_adv_c;
    xfer_c   = s1_v & s2_adv_c;
    in_ready = s1_adv_c;
  end

  // Clear is applied before accumulation so a simultaneous clear+ACC yields in1.
  always_comb begin
    acc_base_c = acc_clr ? '0 : acc;
    res_c      = '0;
    unique case (s1_op)
      OP_AND:  res_c = s1_in1 & s1_in2;
      OP_OR:   res_c = s1_in1 | s1_in2;
      OP_XOR:  res_c = s1_in1 ^ s1_in2;
      OP_NOT:  res_c = ~s1_in1;
      OP_NAND: res_c = ~(s1_in1 & s1_in2);
      OP_NOR:  res_c = ~(s1_in1 | s1_in2);
      OP_XNOR: res_c = ~(s1_in1 ^ s1_in2);
      OP_ACC:  res_c = acc_base_c ^ s1_in1;
    endcase
  end

  // Stage 1: operand capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_op  <= OP_AND;
      s1_in1 <= '0;
      s1_in2 <= '0;
    end else if (s1_adv_c) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_op  <= op_e'(op);
        s1_in1 <= in1;
        s1_in2 <= in2;
      end
    end
  end

  // Stage 2: result, flags and accumulator; all held while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_zero  <= 1'b1;
      out_par   <= 1'b0;
      acc       <= '0;
    end else begin
      if (s2_adv_c) begin
        out_valid <= s1_v;
      end
      if (xfer_c) begin
        out      <= res_c;
        out_zero <= (res_c == '0);
        out_par  <= ^res_c;
        if (s1_op == OP_ACC) begin
          acc <= res_c;
        end else if (acc_clr) begin
          acc <= '0;
        end
      end
    end
  end

`ifdef BITWISE_POPCNT_EN
  localparam int unsigned PW = $clog2(WIDTH + 1);

  logic [PW-1:0] pop_c;

  always_comb begin
    pop_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop_c = pop_c + PW'(res_c[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pop <= '0;
    end else if (xfer_c) begin
      out_pop <= pop_c;
    end
  end
`endif

endmodule
